// File: rtl/divisor16b8b.sv
// rtl/divisor16b8b.sv - sequential restoring divider, one quotient bit per clock
// Shares the START/DONE handshake of multiplicador8b so one controller drives both.
module divisor16b8b #(
  parameter int NW = 16,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [NW-1:0] N,
  input  logic [DW-1:0] D,
  output logic          BUSY,
  output logic          DONE,
  output logic          DIV_ZERO,
  output logic [NW-1:0] Q,
  output logic [DW-1:0] R
);

  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] sn_q, sn_d;
  logic [DW-1:0] sd_q, sd_d;
  // Partial remainder is always < SD after each step, so DW bits hold it.
  logic [DW-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic [NW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;

  logic [DW:0]   trial;
  logic          qbit;

  always_comb begin
    state_d = state_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;
    trial   = {p_q, sn_q[NW-1]};
    qbit    = (trial >= {1'b0, sd_q});

    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          sn_d   = N;
          sd_d   = D;
          p_d    = '0;
          done_d = 1'b0;
          dz_d   = 1'b0;
          if (D != '0) begin
            state_d = ITER;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = FIN;
            q_d     = '1;
            r_d     = N[DW-1:0];
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ITER: begin
        // Difference fits in DW bits whenever the trial value is >= SD.
        p_d   = qbit ? (trial[DW-1:0] - sd_q) : trial[DW-1:0];
        sn_d  = {sn_q[NW-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NW-1)) begin
          q_d     = sn_d;
          r_d     = p_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sn_q    <= '0;
      sd_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign DIV_ZERO = dz_q;
  assign Q        = q_q;
  assign R        = r_q;

endmodule

// File: tb/tb_divisor16b8b.sv
// tb/tb_divisor16b8b.sv - randomized and directed checks of divisor16b8b
// Arithmetic reference model plus literal expectations for the documented cases.
module tb_divisor16b8b;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] n;
  logic [7:0]  d;
  logic        busy, done, dz;
  logic [15:0] q;
  logic [7:0]  r;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  divisor16b8b #(.NW(16), .DW(8)) dut (
    .CLK(clk), .RST(rst), .START(start), .N(n), .D(d),
    .BUSY(busy), .DONE(done), .DIV_ZERO(dz), .Q(q), .R(r)
  );

  always #5 clk = ~clk;

  // Reference model: operands captured on START, result by plain / and %.
  logic        m_busy, m_done, m_dz;
  logic [15:0] m_q, m_n;
  logic [7:0]  m_r, m_d;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_q <= '0; m_r <= '0; m_left <= 0;
    end else if (!m_busy && start) begin
      m_n <= n; m_d <= d; m_done <= 1'b0; m_dz <= 1'b0;
      if (d == 8'd0) begin
        m_done <= 1'b1; m_dz <= 1'b1; m_q <= 16'hFFFF; m_r <= n[7:0];
      end else begin
        m_busy <= 1'b1; m_left <= 16;
      end
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_q <= m_n / 16'(m_d);
        m_r <= 8'(m_n % 16'(m_d));
      end
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({busy, done, dz} !== {m_busy, m_done, m_dz}) begin
        fails++;
        $display("FAIL model_flags t=%0t busy/done/dz got %b%b%b want %b%b%b",
                 $time, busy, done, dz, m_busy, m_done, m_dz);
      end
      tests++;
      if (q !== m_q || r !== m_r) begin
        fails++;
        $display("FAIL model_qr t=%0t got Q=%0d R=%0d want Q=%0d R=%0d",
                 $time, q, r, m_q, m_r);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Captures n/d on the next edge, scrambles the inputs, waits for DONE.
  task automatic run(input logic [15:0] nv, input logic [7:0] dv, input bit hold, output int edges);
    n = nv; d = dv; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    n = 16'($urandom); d = 8'($urandom);
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL done_timeout got %0d edges want done", edges);
    end
  endtask

  int e;
  logic [7:0] a, b;

  initial begin
    rst = 1'b1; start = 1'b0; n = '0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dz", dz, 0);
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    run(16'd65025, 8'd255, 1'b0, e);
    check("lat_65025_255", e, 17);
    check("q_65025_255", q, 255);
    check("r_65025_255", r, 0);

    run(16'd1000, 8'd7, 1'b0, e);
    check("q_1000_7", q, 142);
    check("r_1000_7", r, 6);
    check("dz_1000_7", dz, 0);

    run(16'd65535, 8'd1, 1'b0, e);
    check("q_65535_1", q, 65535);
    check("r_65535_1", r, 0);
    run(16'd5, 8'd200, 1'b0, e);
    check("q_5_200", q, 0);
    check("r_5_200", r, 5);

    run(16'h1232, 8'd0, 1'b0, e);
    check("lat_div0", e, 1);
    check("dz_div0", dz, 1);
    check("q_div0", q, 16'hFFFF);
    check("r_div0", r, 8'h32);

    // START during iteration must be ignored.
    n = 16'd500; d = 8'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; n = 16'd9; d = 8'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    e = 0;
    while (!done && e < 40) begin @(posedge clk); #1; e++; end
    check("ignore_start_q", q, 166);
    check("ignore_start_r", r, 2);

    // Reset mid-iteration aborts.
    n = 16'd500; d = 8'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", q, 0);
    check("abort_r", r, 0);

    // Round trip with products of two 8-bit factors.
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(1, 255));
      b = 8'($urandom_range(1, 255));
      run(16'(a) * 16'(b), b, 1'b0, e);
      check("roundtrip_q", q, 32'(a));
      check("roundtrip_r", r, 0);
    end

    // Fully random operands, back-to-back, sometimes with START held.
    for (int i = 0; i < 60; i++) begin
      run(16'($urandom), (i % 10 == 0) ? 8'd0 : 8'($urandom), bit'($urandom_range(0, 1)), e);
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
